// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the memory controller: instruction fetch and
// load/store ports share one request bus, with a per-transaction timeout fault.
module mem_arbiter #(
    parameter bit          RR_ENABLE = 1'b1,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_read_valid,
    output logic [31:0] i_read_data,
    output logic        i_ready,
    output logic        i_fault,
    input  logic [31:0] d_addr,
    input  logic        d_read_valid,
    input  logic        d_write_valid,
    input  logic [31:0] d_write_data,
    input  logic [1:0]  d_width,
    output logic [31:0] d_read_data,
    output logic        d_ready,
    output logic        d_fault,
    output logic [31:0] mem_addr,
    output logic        mem_read_valid,
    output logic        mem_write_valid,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state, state_nx;
    logic          last_d;
    logic [CW-1:0] cnt;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [1:0]    cap_width;
    logic          cap_write;

    logic i_pend, d_pend, grant_d, busy, expire, done, act;

    always_comb begin
        i_pend   = i_read_valid;
        d_pend   = d_read_valid | d_write_valid;
        // Ties go to whichever port did not win last time, or always to D.
        grant_d  = d_pend && (!i_pend || !RR_ENABLE || !last_d);
        busy     = (state != IDLE);
        expire   = busy && !mem_ready && (cnt == CNT_LAST);
        done     = busy && (mem_ready || expire);
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_pend || d_pend) begin
                    state_nx = grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d    <= 1'b1;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_width <= '0;
            cap_write <= 1'b0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (i_pend || d_pend) begin
                last_d <= grant_d;
                if (grant_d) begin
                    cap_addr  <= d_addr;
                    cap_wdata <= d_write_data;
                    cap_width <= d_width;
                    cap_write <= d_write_valid;
                end else begin
                    cap_addr  <= i_addr;
                    cap_wdata <= '0;
                    cap_width <= 2'd2;
                    cap_write <= 1'b0;
                end
            end
        end else begin
            cnt <= done ? '0 : cnt + CW'(1);
        end
    end

    // Everything towards both sides is gated by rst so a completion arriving
    // in the reset cycle is dropped.
    always_comb begin
        act             = busy && !rst;
        mem_addr        = act ? cap_addr : '0;
        mem_width       = act ? cap_width : '0;
        mem_write_data  = act ? cap_wdata : '0;
        mem_read_valid  = act && !cap_write;
        mem_write_valid = act && cap_write;
        i_ready         = act && (state == BUSY_I) && done;
        i_fault         = act && (state == BUSY_I) && expire;
        d_ready         = act && (state == BUSY_D) && done;
        d_fault         = act && (state == BUSY_D) && expire;
        i_read_data     = (act && (state == BUSY_I) && mem_ready) ? mem_read_data : '0;
        d_read_data     = (act && (state == BUSY_D) && mem_ready && !cap_write) ? mem_read_data : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, d_write_data, mem_read_data;
    logic        i_read_valid, d_read_valid, d_write_valid, mem_ready;
    logic [1:0]  d_width;

    logic [31:0] i_read_data, d_read_data, mem_addr, mem_write_data;
    logic        i_ready, i_fault, d_ready, d_fault, mem_read_valid, mem_write_valid;
    logic [1:0]  mem_width;

    logic [31:0] f_i_read_data, f_d_read_data, f_mem_addr, f_mem_write_data;
    logic        f_i_ready, f_i_fault, f_d_ready, f_d_fault, f_mem_read_valid, f_mem_write_valid;
    logic [1:0]  f_mem_width;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RR_ENABLE(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read_valid(i_read_valid), .i_read_data(i_read_data),
        .i_ready(i_ready), .i_fault(i_fault),
        .d_addr(d_addr), .d_read_valid(d_read_valid), .d_write_valid(d_write_valid),
        .d_write_data(d_write_data), .d_width(d_width), .d_read_data(d_read_data),
        .d_ready(d_ready), .d_fault(d_fault),
        .mem_addr(mem_addr), .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
        .mem_write_data(mem_write_data), .mem_width(mem_width),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready)
    );

    mem_arbiter #(.RR_ENABLE(1'b0), .TIMEOUT(TO)) dut_fx (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read_valid(i_read_valid), .i_read_data(f_i_read_data),
        .i_ready(f_i_ready), .i_fault(f_i_fault),
        .d_addr(d_addr), .d_read_valid(d_read_valid), .d_write_valid(d_write_valid),
        .d_write_data(d_write_data), .d_width(d_width), .d_read_data(f_d_read_data),
        .d_ready(f_d_ready), .d_fault(f_d_fault),
        .mem_addr(f_mem_addr), .mem_read_valid(f_mem_read_valid), .mem_write_valid(f_mem_write_valid),
        .mem_write_data(f_mem_write_data), .mem_width(f_mem_width),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_addr        = '0;
        i_read_valid  = 1'b0;
        d_addr        = '0;
        d_read_valid  = 1'b0;
        d_write_valid = 1'b0;
        d_write_data  = '0;
        d_width       = '0;
        mem_ready     = 1'b0;
        mem_read_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        irv;
        logic [31:0] iaddr;
        logic        drv;
        logic        dwv;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [1:0]  dwidth;
        logic        mrdy;
        logic [31:0] mrdata;
        logic        e_mrv;
        logic        e_mwv;
        logic [31:0] e_maddr;
        logic [1:0]  e_mwidth;
        logic [31:0] e_mwdata;
        logic        e_irdy;
        logic [31:0] e_irdata;
        logic        e_drdy;
        logic [31:0] e_drdata;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  width;
    } req_t;

    req_t        ireq, dreq, cur;
    logic        ipend, dpend, d_rbit, d_wbit, last_d, hang, rdy, busyv, e_done, e_fault;
    int          active, busy_cycles;
    logic [31:0] ram [4];
    logic [31:0] rd_val, exp_rd;

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hFFFF,
                    1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'hDEADBEEF,
                    1'b1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4]  = tbl[3];
        tbl[5]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h13,
                    1'b1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b1, 32'h13, 1'b0, 32'h0};
        tbl[6]  = tbl[0];
        tbl[6].rst = 1'b0;
        tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1004, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1004, 32'hCAFEF00D, 2'd2, 1'b1, 32'h55,
                    1'b0, 1'b1, 32'h1004, 2'd2, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1004, 32'h0, 2'd2, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1004, 32'h0, 2'd2, 1'b1, 32'hCAFEF00D,
                    1'b1, 1'b0, 32'h1004, 2'd2, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D};
        tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2003, 32'hAB, 2'd0, 1'b1, 32'h77,
                    1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2003, 32'hAB, 2'd0, 1'b0, 32'h77,
                    1'b0, 1'b1, 32'h2003, 2'd0, 32'hAB, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2003, 32'hAB, 2'd0, 1'b1, 32'h77,
                    1'b0, 1'b1, 32'h2003, 2'd0, 32'hAB, 1'b0, 32'h0, 1'b1, 32'h0};
        tbl[14] = tbl[6];
        tbl[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3002, 32'h0, 2'd1, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3002, 32'h0, 2'd1, 1'b1, 32'h1234,
                    1'b1, 1'b0, 32'h3002, 2'd1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234};
        tbl[17] = tbl[6];

        idle_inputs();
        rst = 1'b1;

        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            rst           = tbl[n].rst;
            i_read_valid  = tbl[n].irv;
            i_addr        = tbl[n].iaddr;
            d_read_valid  = tbl[n].drv;
            d_write_valid = tbl[n].dwv;
            d_addr        = tbl[n].daddr;
            d_write_data  = tbl[n].dwdata;
            d_width       = tbl[n].dwidth;
            mem_ready     = tbl[n].mrdy;
            mem_read_data = tbl[n].mrdata;
            #1;
            chk1($sformatf("tbl%0d mem_read_valid", n), mem_read_valid, tbl[n].e_mrv);
            chk1($sformatf("tbl%0d mem_write_valid", n), mem_write_valid, tbl[n].e_mwv);
            if (tbl[n].e_mrv || tbl[n].e_mwv || tbl[n].rst) begin
                chk32($sformatf("tbl%0d mem_addr", n), mem_addr, tbl[n].e_maddr);
                chk32($sformatf("tbl%0d mem_width", n), 32'(mem_width), 32'(tbl[n].e_mwidth));
            end
            if (tbl[n].e_mwv || tbl[n].rst)
                chk32($sformatf("tbl%0d mem_write_data", n), mem_write_data, tbl[n].e_mwdata);
            chk1($sformatf("tbl%0d i_ready", n), i_ready, tbl[n].e_irdy);
            chk32($sformatf("tbl%0d i_read_data", n), i_read_data, tbl[n].e_irdata);
            chk1($sformatf("tbl%0d d_ready", n), d_ready, tbl[n].e_drdy);
            chk32($sformatf("tbl%0d d_read_data", n), d_read_data, tbl[n].e_drdata);
            chk1($sformatf("tbl%0d i_fault", n), i_fault, 1'b0);
            chk1($sformatf("tbl%0d d_fault", n), d_fault, 1'b0);
        end

        // Ties: both ports requesting forever, one-cycle memory.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            i_read_valid  = 1'b1;
            i_addr        = 32'h100;
            d_read_valid  = 1'b1;
            d_addr        = 32'h200;
            d_width       = 2'd2;
            mem_ready     = 1'b1;
            mem_read_data = 32'h1111;
            #1;
            chk1($sformatf("rr k%0d i_ready", k), i_ready, (k % 4) == 1);
            chk1($sformatf("rr k%0d d_ready", k), d_ready, (k % 4) == 3);
            if ((k % 2) == 1)
                chk32($sformatf("rr k%0d mem_addr", k), mem_addr, ((k % 4) == 1) ? 32'h100 : 32'h200);
            chk1($sformatf("fx k%0d i_ready", k), f_i_ready, 1'b0);
            chk1($sformatf("fx k%0d d_ready", k), f_d_ready, (k % 2) == 1);
            chk1($sformatf("fx k%0d mem_read_valid", k), f_mem_read_valid, (k % 2) == 1);
            chk32($sformatf("fx k%0d d_read_data", k), f_d_read_data, ((k % 2) == 1) ? 32'h1111 : 32'h0);
            chk32($sformatf("fx k%0d i_read_data", k), f_i_read_data, 32'h0);
            chk1($sformatf("fx k%0d faults", k), f_i_fault | f_d_fault, 1'b0);
            if ((k % 2) == 1) begin
                chk32($sformatf("fx k%0d mem_addr", k), f_mem_addr, 32'h200);
                chk32($sformatf("fx k%0d mem_width", k), 32'(f_mem_width), 32'd2);
            end
        end

        // Store through the fixed-priority instance too.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            d_write_valid = 1'b1;
            d_addr        = 32'h40;
            d_write_data  = 32'hA5A5A5A5;
            d_width       = 2'd1;
            mem_ready     = (k == 1);
            #1;
            chk1($sformatf("fx st k%0d mem_write_valid", k), f_mem_write_valid, k == 1);
            if (k == 1) begin
                chk32("fx st mem_write_data", f_mem_write_data, 32'hA5A5A5A5);
                chk32("fx st mem_width", 32'(f_mem_width), 32'd1);
                chk1("fx st d_ready", f_d_ready, 1'b1);
            end
        end

        // Timeout: memory never answers; fault on the TO-th busy cycle.
        do_reset();
        for (int k = 0; k <= 66; k++) begin
            @(negedge clk);
            d_read_valid  = (k <= 64);
            d_addr        = 32'h5000;
            d_width       = 2'd2;
            mem_ready     = 1'b0;
            mem_read_data = 32'hBADBAD00;
            #1;
            chk1($sformatf("to k%0d d_ready", k), d_ready, k == 64);
            chk1($sformatf("to k%0d d_fault", k), d_fault, k == 64);
            chk32($sformatf("to k%0d d_read_data", k), d_read_data, 32'h0);
            chk1($sformatf("to k%0d mem_read_valid", k), mem_read_valid, (k >= 1) && (k <= 64));
            chk1($sformatf("to k%0d i_ready", k), i_ready, 1'b0);
        end
        // Ready arriving in the last allowed cycle wins over the fault.
        for (int k = 0; k <= 65; k++) begin
            @(negedge clk);
            d_read_valid  = (k <= 64);
            mem_ready     = (k == 64);
            mem_read_data = (k == 64) ? 32'h600DDA7A : 32'hBADBAD00;
            #1;
            chk1($sformatf("to2 k%0d d_ready", k), d_ready, k == 64);
            chk1($sformatf("to2 k%0d d_fault", k), d_fault, 1'b0);
            chk32($sformatf("to2 k%0d d_read_data", k), d_read_data, (k == 64) ? 32'h600DDA7A : 32'h0);
        end

        // Reset while a store is on the bus.
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            idle_inputs();
            rst = (k == 2);
            if (k <= 2) begin
                d_write_valid = 1'b1;
                d_addr        = 32'h6000;
                d_write_data  = 32'h12345678;
                d_width       = 2'd2;
            end
            if (k == 3 || k == 4) begin
                i_read_valid = 1'b1;
                i_addr       = 32'h700;
            end
            mem_ready     = (k >= 2 && k <= 4);
            mem_read_data = 32'h99;
            #1;
            chk1($sformatf("rm k%0d d_ready", k), d_ready, 1'b0);
            chk1($sformatf("rm k%0d mem_write_valid", k), mem_write_valid, k == 1);
            if (k != 2)
                chk1($sformatf("rm k%0d mem_read_valid", k), mem_read_valid, k == 4);
            chk1($sformatf("rm k%0d i_ready", k), i_ready, k == 4);
            chk32($sformatf("rm k%0d i_read_data", k), i_read_data, (k == 4) ? 32'h99 : 32'h0);
            if (k == 4)
                chk32("rm mem_addr", mem_addr, 32'h700);
        end

        // Randomized traffic against the transaction-level model.
        do_reset();
        ipend = 1'b0; dpend = 1'b0; d_rbit = 1'b0; d_wbit = 1'b0;
        last_d = 1'b1; active = 0; busy_cycles = 0; hang = 1'b0;
        cur = '{32'h0, 1'b0, 32'h0, 2'd0};
        ireq = cur; dreq = cur;
        for (int j = 0; j < 4; j++) ram[j] = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!ipend && ($urandom_range(0, 2) == 0)) begin
                ipend      = 1'b1;
                ireq.addr  = 32'h100 + {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                ireq.wr    = 1'b0;
                ireq.wdata = 32'h0;
                ireq.width = 2'd2;
            end
            if (!dpend && ($urandom_range(0, 2) == 0)) begin
                int op;
                op         = int'($urandom_range(0, 2));
                dpend      = 1'b1;
                d_rbit     = (op != 1);
                d_wbit     = (op != 0);
                dreq.addr  = 32'h1000 + {28'b0, 2'($urandom_range(0, 3)), 2'b00};
                dreq.wr    = d_wbit;
                dreq.wdata = $urandom;
                dreq.width = 2'($urandom_range(0, 2));
            end
            i_read_valid  = ipend;
            i_addr        = ipend ? ireq.addr : $urandom;
            d_read_valid  = dpend && d_rbit;
            d_write_valid = dpend && d_wbit;
            d_addr        = dpend ? dreq.addr : $urandom;
            d_write_data  = dpend ? dreq.wdata : $urandom;
            d_width       = dpend ? dreq.width : 2'($urandom_range(0, 3));

            busyv  = (active != 0);
            rdy    = busyv ? (!hang && ($urandom_range(0, 2) == 0)) : ($urandom_range(0, 3) == 0);
            rd_val = (active == 1) ? fetch_word(cur.addr) : ram[cur.addr[3:2]];
            mem_ready     = rdy;
            mem_read_data = (busyv && !cur.wr && rdy) ? rd_val : $urandom;
            #1;
            e_done  = busyv && (rdy || (busy_cycles == TO - 1));
            e_fault = busyv && !rdy && (busy_cycles == TO - 1);
            exp_rd  = (busyv && rdy && !cur.wr) ? rd_val : 32'h0;
            chk1($sformatf("rnd c%0d mem_read_valid", c), mem_read_valid, busyv && !cur.wr);
            chk1($sformatf("rnd c%0d mem_write_valid", c), mem_write_valid, busyv && cur.wr);
            if (busyv) begin
                chk32($sformatf("rnd c%0d mem_addr", c), mem_addr, cur.addr);
                chk32($sformatf("rnd c%0d mem_width", c), 32'(mem_width), 32'(cur.width));
            end
            if (busyv && cur.wr)
                chk32($sformatf("rnd c%0d mem_write_data", c), mem_write_data, cur.wdata);
            chk1($sformatf("rnd c%0d i_ready", c), i_ready, (active == 1) && e_done);
            chk1($sformatf("rnd c%0d i_fault", c), i_fault, (active == 1) && e_fault);
            chk32($sformatf("rnd c%0d i_read_data", c), i_read_data, (active == 1) ? exp_rd : 32'h0);
            chk1($sformatf("rnd c%0d d_ready", c), d_ready, (active == 2) && e_done);
            chk1($sformatf("rnd c%0d d_fault", c), d_fault, (active == 2) && e_fault);
            chk32($sformatf("rnd c%0d d_read_data", c), d_read_data, (active == 2) ? exp_rd : 32'h0);

            if (busyv) begin
                if (e_done) begin
                    if (rdy && cur.wr) ram[cur.addr[3:2]] = cur.wdata;
                    if (active == 1) ipend = 1'b0;
                    else dpend = 1'b0;
                    active = 0;
                end else begin
                    busy_cycles++;
                end
            end else if (ipend || dpend) begin
                logic pick_d;
                pick_d      = dpend && (!ipend || !last_d);
                active      = pick_d ? 2 : 1;
                cur         = pick_d ? dreq : ireq;
                last_d      = pick_d;
                busy_cycles = 0;
                hang        = ($urandom_range(0, 19) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that sits directly upstream of the memory controller.
- Merges the CPU instruction-fetch port (read-only, word) and the load/store data port (read/write, B/H/W) onto the single controller request bus.
- Latches the winning request and holds it stable until the controller responds.
- A timeout converts a hung transaction (e.g. an unmapped address that never gets ready) into a fault pulse.

Parameters:
RR_ENABLE, 1, 1 = round-robin on ties; 0 = data port always wins ties
TIMEOUT, 64, max cycles in a busy state without mem_ready before forced fault completion (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_addr  input  32  fetch address
i_read_valid  input  1  fetch request; held until i_ready
i_read_data  output  32  fetch data, valid when i_ready
i_ready  output  1  one-cycle fetch completion
i_fault  output  1  one-cycle timeout fault, coincident with i_ready
d_addr  input  32  data address
d_read_valid  input  1  load request; held until d_ready
d_write_valid  input  1  store request; held until d_ready
d_write_data  input  32  store data
d_width  input  2  0=B, 1=H, 2=W
d_read_data  output  32  load data, valid when d_ready
d_ready  output  1  one-cycle data completion
d_fault  output  1  one-cycle timeout fault, coincident with d_ready
mem_addr  output  32  to controller
mem_read_valid  output  1  to controller
mem_write_valid  output  1  to controller
mem_write_data  output  32  to controller
mem_width  output  2  to controller
mem_read_data  input  32  from controller
mem_ready  input  1  from controller

Behaviour:
- Reset:
  - State IDLE; last_grant = D; timeout counter = 0.
  - All mem_* outputs 0; i_ready, d_ready, i_fault, d_fault = 0; read data outputs 0.
  - Reset mid-transaction abandons the request; any mem_ready in the reset cycle is ignored.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, request detection:
  - Fetch pending = i_read_valid.
  - Data pending = d_read_valid | d_write_valid.
- IDLE, grant:
  - One port pending: grant it.
  - Both pending, RR_ENABLE=1: grant the port not equal to last_grant.
  - Both pending, RR_ENABLE=0: grant D.
- IDLE, capture on grant:
  - Register addr, width, wdata and op.
  - Fetch is captured as width 2 (W), read only.
  - If d_read_valid and d_write_valid are both high, the request is treated as a write.
  - Update last_grant and go to BUSY_x next cycle.
  - No mem_* valid is driven in IDLE, so arbitration costs exactly one cycle.
- BUSY_x, request phase:
  - Drive mem_* from the captured registers.
  - Exactly one of mem_read_valid/mem_write_valid is high; values are stable for the whole state.
  - Port inputs are ignored while busy; the other port simply waits.
- BUSY_x, completion on mem_ready=1:
  - x_ready=1 (combinational from mem_ready).
  - x_read_data = mem_read_data; 0 for writes.
  - Next state IDLE, counter cleared.
  - The non-granted port's ready is never asserted.
- Minimum cost per transaction: 2 cycles (IDLE + BUSY with immediate ready).
- Back-to-back: a requester drops or changes its request in the cycle after its ready. Because the arbiter is in IDLE that cycle, the stale request is never re-captured.
- Timeout:
  - The counter increments each BUSY cycle without mem_ready.
  - In the busy cycle where counter == TIMEOUT-1, with mem_ready still low:
    - assert x_ready and x_fault for one cycle, with x_read_data = 0;
    - deassert mem_*_valid next cycle and return to IDLE.
  - mem_ready in that same cycle takes precedence: normal completion, no fault.
- Read data outputs are 0 whenever their ready is low.

Test Plan:
- Single fetch: i_addr=0x100, controller ready after 3 cycles with data 0x00000013 -> mem_read_valid high 3 cycles, mem_width=2; i_ready pulses with i_read_data=0x13; d_ready stays 0.
- Store then load: d_write_valid, addr 0x1004, wdata 0xCAFEF00D, width 2, ready immediate -> d_ready in 2nd cycle, d_read_data=0. Then load 0x1004 returning 0xCAFEF00D -> d_read_data=0xCAFEF00D.
- Tie, RR_ENABLE=1: both ports request continuously from reset -> grant order I, D, I, D; each port's ready every 4 cycles with 1-cycle memory.
- Tie, RR_ENABLE=0: both ports request continuously -> D granted every transaction; i_ready never asserts while D is pending.
- Timeout: d_read_valid addr 0x5000, mem_ready held 0 -> d_ready and d_fault pulse together after 64 busy cycles, d_read_data=0; returns to IDLE. A ready in cycle 64 instead -> no fault.
- Reset mid-op: assert rst during BUSY_D -> next cycle all mem_* valids 0, no ready pulses; a fresh fetch afterwards completes normally.
